onchip_ram_loader: RTL and testbench

Boot-time initiator for the 16-bit single-port on-chip RAM. It accepts a big-endian byte stream over a valid/ready handshake and packs bytes into 16-bit words. It writes the words sequentially from word address 0 using byte enables, and holds the J68 core in reset until the image is loaded. It also keeps a 16-bit additive checksum of the loaded image.

---
 rtl/j68_mem_pkg.sv | 26 ++
 rtl/loader_pack.sv | 73 +++++++
 rtl/onchip_ram_loader.sv | 195 +++++++++++++++++++
 tb/tb_onchip_ram_loader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/j68_mem_pkg.sv
// Shared definitions for the on-chip RAM boot loader.
//   loader_state_t : FSM state encoding (VERIFY is only reachable when
//                    LOADER_VERIFY_EN is defined)
//   LANE_*         : RAM byte-enable patterns, bit 1 = data[15:8] (even byte)
//   clamp_len      : limits a requested image length to the RAM size
package j68_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } loader_state_t;

    localparam logic [1:0] LANE_HI = 2'b10;
    localparam logic [1:0] LANE_LO = 2'b01;
    localparam logic [1:0] LANE_W  = 2'b11;

    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned addr_width);
        int unsigned max_len;
        max_len = 32'd1 << addr_width;
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/loader_pack.sv
// Byte-to-word packer for the boot loader.
// Big-endian: the even byte of each pair goes to data[15:8]. A write pulse
// is produced the cycle after the odd byte (or a trailing even byte of an
// odd-length image) is accepted. Between writes the address register can be
// loaded with a read address for readback.
// Ports:
//   clock, reset_n     : clock, async active-low reset
//   clear              : restart the byte pointer at 0 (load start)
//   accept, data_in    : byte handshake completed this cycle, and its value
//   last               : the accepted byte is the final byte of the image
//   rd_en, rd_addr     : load a read address when no byte is accepted
//   ram_wren/byteena/address/data : registered RAM write interface
import j68_mem_pkg::*;

module loader_pack #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  accept,
    input  logic                  last,
    input  logic [7:0]            data_in,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-2:0] rd_addr,
    output logic                  ram_wren,
    output logic [1:0]            ram_byteena,
    output logic [ADDR_WIDTH-2:0] ram_address,
    output logic [15:0]           ram_data
);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;

    logic [ADDR_WIDTH-1:0] ptr;
    logic [7:0]            stage;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr         <= '0;
            stage       <= '0;
            ram_wren    <= 1'b0;
            ram_byteena <= '0;
            ram_address <= '0;
            ram_data    <= '0;
        end else begin
            // write strobe and lanes are single-cycle
            ram_wren    <= 1'b0;
            ram_byteena <= '0;
            if (clear) begin
                ptr <= '0;
            end else if (accept) begin
                ptr <= ptr + PTR_ONE;
                if (!ptr[0]) begin
                    stage <= data_in;
                    if (last) begin
                        ram_wren    <= 1'b1;
                        ram_byteena <= LANE_HI;
                        ram_address <= ptr[ADDR_WIDTH-1:1];
                        ram_data    <= {data_in, 8'h00};
                    end
                end else begin
                    ram_wren    <= 1'b1;
                    ram_byteena <= LANE_W;
                    ram_address <= ptr[ADDR_WIDTH-1:1];
                    ram_data    <= {stage, data_in};
                end
            end else if (rd_en) begin
                ram_address <= rd_addr;
            end
        end
    end

endmodule

// File: rtl/onchip_ram_loader.sv
// Boot-time loader for the 16-bit on-chip RAM of the J68 core.
// Takes a big-endian byte stream (valid/ready), writes it from word 0 and
// holds the CPU in reset until the image is in place. Keeps a 16-bit
// additive checksum of the image.
// Optional build macro: LOADER_VERIFY_EN adds a readback pass that sums the
// written lanes and flags a mismatch against the checksum on 'error'.
// Ports:
//   clock, reset_n          : clock, async active-low reset
//   start, length           : load request (IDLE only) and image size in bytes
//   s_valid, s_data, s_ready: byte stream handshake
//   ram_wren/byteena/address/data, ram_q : single-port RAM interface
//   busy, cpu_hold, done    : status, CPU reset request, completion pulse
//   checksum, error         : image sum mod 2^16, readback mismatch
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | waiting for start
// ST_LOAD   | accepting bytes, writing words
// ST_VERIFY | reading back written words (LOADER_VERIFY_EN only)
// ST_DONE   | one cycle; done pulses on the following cycle
import j68_mem_pkg::*;

module onchip_ram_loader #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic                  ram_wren,
    output logic [1:0]            ram_byteena,
    output logic [ADDR_WIDTH-2:0] ram_address,
    output logic [15:0]           ram_data,
    input  logic [15:0]           ram_q,
    output logic                  busy,
    output logic                  cpu_hold,
    output logic                  done,
    output logic [15:0]           checksum,
    output logic                  error
);

    localparam logic [ADDR_WIDTH:0] REM_ONE = 1;

`ifdef LOADER_VERIFY_EN
    localparam loader_state_t LOAD_EXIT = ST_VERIFY;
`else
    localparam loader_state_t LOAD_EXIT = ST_DONE;
`endif

    loader_state_t         state, next_state;
    logic [ADDR_WIDTH:0]   remaining;
    logic [ADDR_WIDTH:0]   len_clamped;
    logic                  start_ok;
    logic                  accept;
    logic                  last_byte;
    logic                  verify_done;
    logic                  rd_en;
    logic [ADDR_WIDTH-2:0] rd_addr;
    logic                  busy_nx;
    logic                  done_nx;

    assign len_clamped = (ADDR_WIDTH+1)'(clamp_len(32'(length), ADDR_WIDTH));
    assign start_ok    = (state == ST_IDLE) && start;
    assign s_ready     = (state == ST_LOAD) && (remaining != '0);
    assign accept      = s_valid && s_ready;
    assign last_byte   = accept && (remaining == REM_ONE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (start) next_state = (len_clamped == '0) ? ST_DONE : ST_LOAD;
            ST_LOAD:   if (last_byte) next_state = LOAD_EXIT;
            ST_VERIFY: if (verify_done) next_state = ST_DONE;
            ST_DONE:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_nx = (next_state != ST_IDLE);
        done_nx = (state == ST_DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            cpu_hold <= 1'b1;
        end else begin
            busy <= busy_nx;
            done <= done_nx;
            if (start_ok)     cpu_hold <= 1'b1;
            else if (done_nx) cpu_hold <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            remaining <= '0;
            checksum  <= '0;
        end else if (start_ok) begin
            remaining <= len_clamped;
            checksum  <= '0;
        end else if (accept) begin
            remaining <= remaining - REM_ONE;
            checksum  <= checksum + {8'h00, s_data};
        end
    end

    loader_pack #(.ADDR_WIDTH(ADDR_WIDTH)) u_pack (
        .clock       (clock),
        .reset_n     (reset_n),
        .clear       (start_ok),
        .accept      (accept),
        .last        (last_byte),
        .data_in     (s_data),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .ram_wren    (ram_wren),
        .ram_byteena (ram_byteena),
        .ram_address (ram_address),
        .ram_data    (ram_data)
    );

`ifdef LOADER_VERIFY_EN
    localparam logic [ADDR_WIDTH-1:0] WORD_ONE = 1;

    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH-1:0] words;
    logic [ADDR_WIDTH-1:0] issued;
    logic                  issue_last;
    logic                  addr_vld, addr_last;
    logic                  q_vld, q_last;
    logic [15:0]           vsum, lane_sum, vsum_next;

    assign words      = len_q[ADDR_WIDTH:1] + {{(ADDR_WIDTH-1){1'b0}}, len_q[0]};
    assign issue_last = (issued == words - WORD_ONE);
    assign rd_en      = (state == ST_VERIFY) && (issued != words);
    assign rd_addr    = issued[ADDR_WIDTH-2:0];
    // Leave VERIFY as the last address goes out; its data is summed while
    // in DONE so error settles on the same edge that raises done.
    assign verify_done = addr_vld && addr_last;
    // trailing word of an odd-length image only has its upper lane written
    assign lane_sum  = {8'h00, ram_q[15:8]} +
                       ((q_last && len_q[0]) ? 16'h0000 : {8'h00, ram_q[7:0]});
    assign vsum_next = vsum + lane_sum;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            len_q     <= '0;
            issued    <= '0;
            addr_vld  <= 1'b0;
            addr_last <= 1'b0;
            q_vld     <= 1'b0;
            q_last    <= 1'b0;
            vsum      <= '0;
            error     <= 1'b0;
        end else if (start_ok) begin
            len_q     <= len_clamped;
            issued    <= '0;
            addr_vld  <= 1'b0;
            addr_last <= 1'b0;
            q_vld     <= 1'b0;
            q_last    <= 1'b0;
            vsum      <= '0;
            error     <= 1'b0;
        end else begin
            addr_vld  <= rd_en;
            addr_last <= rd_en && issue_last;
            q_vld     <= addr_vld;
            q_last    <= addr_last;
            if (rd_en) issued <= issued + WORD_ONE;
            if (q_vld) vsum <= vsum_next;
            if (q_vld && q_last && (vsum_next != checksum)) error <= 1'b1;
        end
    end
`else
    logic unused_q;

    assign unused_q    = ^ram_q;
    assign rd_en       = 1'b0;
    assign rd_addr     = '0;
    assign verify_done = 1'b0;
    assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_onchip_ram_loader.sv
`timescale 1ns/1ps
module tb_onchip_ram_loader;

    localparam int AW = 12;
`ifdef LOADER_VERIFY_EN
    localparam int DONE_LAG4 = 4;   // last write -> done for a 4-byte image
`else
    localparam int DONE_LAG4 = 1;
`endif

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   length = '0;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = 8'h00;
    logic          s_ready;
    logic          ram_wren;
    logic [1:0]    ram_byteena;
    logic [AW-2:0] ram_address;
    logic [15:0]   ram_data;
    logic [15:0]   ram_q = 16'h0000;
    logic          busy, cpu_hold, done, error;
    logic [15:0]   checksum;

    always #5 clock = ~clock;

    onchip_ram_loader #(.ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .length(length),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .ram_wren(ram_wren), .ram_byteena(ram_byteena), .ram_address(ram_address),
        .ram_data(ram_data), .ram_q(ram_q), .busy(busy), .cpu_hold(cpu_hold),
        .done(done), .checksum(checksum), .error(error)
    );

    // synchronous single-port RAM model, optional corruption of word 1
    logic [15:0] mem [0:(1<<(AW-1))-1];
    bit          corrupt = 1'b0;
    always @(posedge clock) begin
        logic [15:0] w;
        if (ram_wren) begin
            w = mem[ram_address];
            if (ram_byteena[1]) w[15:8] = ram_data[15:8];
            if (ram_byteena[0]) w[7:0]  = ram_data[7:0];
            if (corrupt && ram_address == 1) w = w + 16'h0001;
            mem[ram_address] <= w;
        end
        ram_q <= mem[ram_address];
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [31:0] wr_log[$];   // {3'b0, byteena, address, data}
    int   last_wr_cyc = 0, done_cyc = 0, done_cnt = 0;
    logic hold_at_done = 1'bx, busy_at_done = 1'bx, err_at_done = 1'bx;

    always @(negedge clock) begin
        if (reset_n && ram_wren) begin
            wr_log.push_back({3'b000, ram_byteena, ram_address, ram_data});
            last_wr_cyc = cyc;
        end
        if (reset_n && done) begin
            done_cnt++;
            done_cyc     = cyc;
            hold_at_done = cpu_hold;
            busy_at_done = busy;
            err_at_done  = error;
        end
    end

    int checks = 0, failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input string tag, input int k, input logic [1:0] be,
                            input logic [10:0] a, input logic [15:0] d);
        logic [31:0] obs;
        obs = (k < wr_log.size()) ? wr_log[k] : 32'hxxxxxxxx;
        check(tag, obs, {3'b000, be, a, d});
    endtask

    logic [7:0] img [0:7];

    task automatic begin_load(input int len);
        wr_log.delete();
        start  = 1'b1;
        length = (AW+1)'(len);
        @(negedge clock);
        start  = 1'b0;
    endtask

    task automatic send(input int count, input bit toggle);
        int i = 0;
        int budget = 0;
        bit gap = 1'b0;
        while (i < count && budget < 200) begin
            if (toggle && gap) begin
                s_valid = 1'b0;
                s_data  = 8'hEE;
            end else begin
                s_valid = 1'b1;
                s_data  = img[i];
            end
            if (s_valid && s_ready) i++;
            gap = !gap;
            budget++;
            @(negedge clock);
        end
        s_valid = 1'b0;
        check("bytes_accepted", 32'(i), 32'(count));
    endtask

    task automatic wait_done(input int base);
        int b = 0;
        while (done_cnt == base && b < 100) begin
            @(negedge clock);
            b++;
        end
        repeat (3) @(negedge clock);
        check("done_once", 32'(done_cnt), 32'(base + 1));
    endtask

    int base, sc;

    initial begin
        for (int i = 0; i < (1 << (AW-1)); i++) mem[i] = 16'h0000;
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clock);

        check("rst_s_ready",  32'(s_ready), 0);
        check("rst_wren",     32'(ram_wren), 0);
        check("rst_byteena",  32'(ram_byteena), 0);
        check("rst_address",  32'(ram_address), 0);
        check("rst_data",     32'(ram_data), 0);
        check("rst_busy",     32'(busy), 0);
        check("rst_cpu_hold", 32'(cpu_hold), 1);
        check("rst_done",     32'(done), 0);
        check("rst_checksum", 32'(checksum), 0);
        check("rst_error",    32'(error), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check("idle_cpu_hold", 32'(cpu_hold), 1);

        // 4-byte image, valid held high
        img[0] = 8'h12; img[1] = 8'h34; img[2] = 8'h56; img[3] = 8'h78;
        base = done_cnt;
        begin_load(4);
        check("t1_busy_after_start", 32'(busy), 1);
        check("t1_s_ready", 32'(s_ready), 1);
        send(4, 1'b0);
        wait_done(base);
        check("t1_nwrites", 32'(wr_log.size()), 2);
        check_wr("t1_w0", 0, 2'b11, 11'd0, 16'h1234);
        check_wr("t1_w1", 1, 2'b11, 11'd1, 16'h5678);
        check("t1_checksum", 32'(checksum), 32'h0114);
        check("t1_done_lag", 32'(done_cyc - last_wr_cyc), 32'(DONE_LAG4));
        check("t1_hold_at_done", 32'(hold_at_done), 0);
        check("t1_busy_at_done", 32'(busy_at_done), 0);
        check("t1_err_at_done", 32'(err_at_done), 0);
        check("t1_hold_after", 32'(cpu_hold), 0);

        // 3-byte image, trailing half word
        img[0] = 8'hAA; img[1] = 8'hBB; img[2] = 8'hCC;
        base = done_cnt;
        begin_load(3);
        check("t2_cpu_hold_set", 32'(cpu_hold), 1);
        send(3, 1'b0);
        wait_done(base);
        check("t2_nwrites", 32'(wr_log.size()), 2);
        check_wr("t2_w0", 0, 2'b11, 11'd0, 16'hAABB);
        check_wr("t2_w1", 1, 2'b10, 11'd1, 16'hCC00);
        check("t2_checksum", 32'(checksum), 32'h0231);

        // zero-length image
        base = done_cnt;
        sc = cyc;
        begin_load(0);
        wait_done(base);
        check("t3_nwrites", 32'(wr_log.size()), 0);
        check("t3_done_lag", 32'(done_cyc - sc), 2);
        check("t3_checksum", 32'(checksum), 0);

        // 6-byte image with gaps in s_valid
        img[0] = 8'hA1; img[1] = 8'hB2; img[2] = 8'hC3;
        img[3] = 8'hD4; img[4] = 8'hE5; img[5] = 8'hF6;
        base = done_cnt;
        begin_load(6);
        send(6, 1'b1);
        wait_done(base);
        check("t4_nwrites", 32'(wr_log.size()), 3);
        check_wr("t4_w0", 0, 2'b11, 11'd0, 16'hA1B2);
        check_wr("t4_w1", 1, 2'b11, 11'd1, 16'hC3D4);
        check_wr("t4_w2", 2, 2'b11, 11'd2, 16'hE5F6);
        check("t4_checksum", 32'(checksum), 32'h04C5);
        check("t4_mem2", 32'(mem[2]), 32'hE5F6);

        // reset in the middle of an 8-byte image
        img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
        img[4] = 8'h55; img[5] = 8'h66; img[6] = 8'h77; img[7] = 8'h88;
        begin_load(8);
        send(3, 1'b0);
        check("t5_checksum_mid", 32'(checksum), 32'h0066);
        reset_n = 1'b0;
        #1;
        check("t5_s_ready",  32'(s_ready), 0);
        check("t5_wren",     32'(ram_wren), 0);
        check("t5_address",  32'(ram_address), 0);
        check("t5_data",     32'(ram_data), 0);
        check("t5_busy",     32'(busy), 0);
        check("t5_cpu_hold", 32'(cpu_hold), 1);
        check("t5_checksum", 32'(checksum), 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        img[0] = 8'h5A; img[1] = 8'hA5;
        base = done_cnt;
        begin_load(2);
        send(2, 1'b0);
        wait_done(base);
        check("t5_nwrites", 32'(wr_log.size()), 1);
        check_wr("t5_w0", 0, 2'b11, 11'd0, 16'h5AA5);
        check("t5_checksum_new", 32'(checksum), 32'h00FF);
        check("t5_hold_after", 32'(cpu_hold), 0);

`ifdef LOADER_VERIFY_EN
        img[0] = 8'h12; img[1] = 8'h34; img[2] = 8'h56; img[3] = 8'h78;
        corrupt = 1'b1;
        base = done_cnt;
        begin_load(4);
        send(4, 1'b0);
        wait_done(base);
        check("v_err_corrupt", 32'(err_at_done), 1);
        check("v_err_sticky", 32'(error), 1);
        check("v_mem1", 32'(mem[1]), 32'h5679);
        corrupt = 1'b0;
        base = done_cnt;
        begin_load(4);
        check("v_err_cleared", 32'(error), 0);
        send(4, 1'b0);
        wait_done(base);
        check("v_err_clean", 32'(err_at_done), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
